// File: rtl/piso_serializer.sv
// Parallel-in, serial-out serializer.
// Takes a WIDTH-bit word through a valid/ready handshake and shifts it out
// MSB first, one bit per clock, flagged by bit_valid. After each word the
// block idles for GAP_CYCLES cycles. With GAP_CYCLES=0, a new word can be
// accepted in the last bit cycle, so consecutive words stream with no bubble.
module piso_serializer #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1   // legal range 0..15
) (
  input  logic             clk,
  input  logic             reset,      // asynchronous, active low
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [3:0]       GAP_LOAD = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit               NO_GAP   = (GAP_CYCLES == 0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_shift;     // MSB is the bit currently on serial_out
  logic [CNT_W-1:0] r_bit_cnt;   // index k of the current bit cycle
  logic [3:0]       r_gap_cnt;   // remaining gap cycles minus one

  logic w_last_bit;
  logic w_ready;
  logic w_accept;

  assign w_last_bit = (r_state == ST_SHIFT) && (r_bit_cnt == LAST_BIT);

  // Ready only outside reset: in IDLE, or in the last bit cycle when words
  // may follow each other without a gap.
  assign w_ready  = reset && ((r_state == ST_IDLE) || (w_last_bit && NO_GAP));
  assign w_accept = din_valid && w_ready;

  // Serial_out comes straight from the shift register flop. Once a word has
  // been shifted out completely the register holds zero, so the line idles
  // low without extra gating.
  assign serial_out = r_shift[WIDTH-1];
  assign bit_valid  = (r_state == ST_SHIFT);
  assign word_done  = w_last_bit;
  assign busy       = (r_state != ST_IDLE);
  assign din_ready  = w_ready;

  // State, shift register and counters; reset drops any partial word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_shift   <= din;
            r_bit_cnt <= '0;
            r_state   <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (w_accept) begin
            // Only reachable in the last bit cycle with no gap: chain the next word.
            r_shift   <= din;
            r_bit_cnt <= '0;
          end else begin
            r_shift <= r_shift << 1;
            if (w_last_bit) begin
              if (NO_GAP) begin
                r_state <= ST_IDLE;
              end else begin
                r_state   <= ST_GAP;
                r_gap_cnt <= GAP_LOAD;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
        end

        ST_GAP: begin
          if (r_gap_cnt == 4'd0) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer. Instance A uses GAP_CYCLES=1 and instance B
// uses GAP_CYCLES=0. Expected bits are queued when a word is accepted, then
// popped and compared whenever a DUT flags bit_valid. A small 8-bit shift
// register fed by A's serial stream models the downstream receiver.
module tb_piso_serializer;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic       clk;
  logic       reset;

  logic [7:0] a_din;
  logic       a_din_valid, a_din_ready, a_serial_out, a_bit_valid, a_word_done, a_busy;
  logic [7:0] b_din;
  logic       b_din_valid, b_din_ready, b_serial_out, b_bit_valid, b_word_done, b_busy;

  logic [7:0] ds_a;   // downstream 8-bit shift register fed by instance A

  exp_t qa[$];
  exp_t qb[$];
  int   checks   = 0;
  int   failures = 0;
  bit   last_acc_a, last_acc_b;

  piso_serializer #(.WIDTH(8), .GAP_CYCLES(1)) u_dut_a (
    .clk(clk), .reset(reset), .din(a_din), .din_valid(a_din_valid),
    .din_ready(a_din_ready), .serial_out(a_serial_out), .bit_valid(a_bit_valid),
    .word_done(a_word_done), .busy(a_busy)
  );

  piso_serializer #(.WIDTH(8), .GAP_CYCLES(0)) u_dut_b (
    .clk(clk), .reset(reset), .din(b_din), .din_valid(b_din_valid),
    .din_ready(b_din_ready), .serial_out(b_serial_out), .bit_valid(b_bit_valid),
    .word_done(b_word_done), .busy(b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream receiver: shifts in serial_out whenever bit_valid is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ds_a <= '0;
    else if (a_bit_valid) ds_a <= {ds_a[6:0], a_serial_out};
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock: queue accepted words, take the edge, then check both streams.
  task automatic tick();
    bit   acc_a, acc_b;
    exp_t e;
    acc_a = a_din_valid && a_din_ready;
    acc_b = b_din_valid && b_din_ready;
    if (acc_a) for (int i = 7; i >= 0; i--) qa.push_back('{b: a_din[i], last: (i == 0)});
    if (acc_b) for (int i = 7; i >= 0; i--) qb.push_back('{b: b_din[i], last: (i == 0)});
    @(posedge clk);
    #1;
    last_acc_a = acc_a;
    last_acc_b = acc_b;
    if (a_bit_valid) begin
      if (qa.size() == 0) check("a_unexpected_bit", a_bit_valid, 1'b0);
      else begin
        e = qa.pop_front();
        check("a_serial", a_serial_out, e.b);
        check("a_word_done", a_word_done, e.last);
      end
    end else begin
      check("a_idle_serial", a_serial_out, 1'b0);
      check("a_idle_word_done", a_word_done, 1'b0);
    end
    if (b_bit_valid) begin
      if (qb.size() == 0) check("b_unexpected_bit", b_bit_valid, 1'b0);
      else begin
        e = qb.pop_front();
        check("b_serial", b_serial_out, e.b);
        check("b_word_done", b_word_done, e.last);
      end
    end else begin
      check("b_idle_serial", b_serial_out, 1'b0);
      check("b_idle_word_done", b_word_done, 1'b0);
    end
  endtask

  initial begin
    int n;
    reset       = 1'b0;
    a_din       = 8'h00;
    a_din_valid = 1'b0;
    b_din       = 8'h00;
    b_din_valid = 1'b0;
    last_acc_a  = 1'b0;
    last_acc_b  = 1'b0;

    // Reset state.
    #3;
    check("rst_a_serial", a_serial_out, 1'b0);
    check("rst_a_bit_valid", a_bit_valid, 1'b0);
    check("rst_a_word_done", a_word_done, 1'b0);
    check("rst_a_busy", a_busy, 1'b0);
    check("rst_a_din_ready", a_din_ready, 1'b0);
    check("rst_b_din_ready", b_din_ready, 1'b0);
    check("rst_b_busy", b_busy, 1'b0);

    // Release between edges; ready must follow combinationally.
    #9 reset = 1'b1;
    #1;
    check("rel_a_din_ready", a_din_ready, 1'b1);
    check("rel_b_din_ready", b_din_ready, 1'b1);

    // Idle hold for 20 cycles.
    for (int c = 0; c < 20; c++) begin
      tick();
      check("idle_a_bit_valid", a_bit_valid, 1'b0);
      check("idle_a_busy", a_busy, 1'b0);
      check("idle_a_din_ready", a_din_ready, 1'b1);
    end

    // Basic word 8'hB2 with one gap cycle.
    a_din = 8'hB2;
    a_din_valid = 1'b1;
    tick();
    check("b2_accepted", last_acc_a, 1'b1);
    a_din_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) tick();
      check("b2_din_ready", a_din_ready, (c == 10));
      check("b2_busy", a_busy, (c <= 9));
      check("b2_bit_valid", a_bit_valid, (c <= 8));
      if (c == 9) check("b2_downstream", ds_a, 8'hB2);
    end
    check("b2_queue_empty", qa.size(), 0);

    // Backpressure: din changes to 8'h3C while A5 is in flight.
    a_din = 8'hA5;
    a_din_valid = 1'b1;
    tick();
    check("bp_a5_accepted", last_acc_a, 1'b1);
    a_din = 8'h3C;
    n = 21;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (last_acc_a) begin
        n = k;
        break;
      end
    end
    check("bp_3c_accept_cycle", n, 10);
    a_din_valid = 1'b0;
    for (int k = 0; k < 11; k++) tick();
    check("bp_downstream", ds_a, 8'h3C);
    check("bp_queue_empty", qa.size(), 0);

    // Back-to-back on the no-gap instance: FF then 00.
    b_din = 8'hFF;
    b_din_valid = 1'b1;
    tick();
    check("b2b_ff_accepted", last_acc_b, 1'b1);
    b_din = 8'h00;
    check("b2b_bit_valid", b_bit_valid, 1'b1);
    for (int k = 2; k <= 16; k++) begin
      tick();
      if (last_acc_b) b_din_valid = 1'b0;
      check("b2b_bit_valid", b_bit_valid, 1'b1);
      if (k == 8) check("b2b_ready_last_bit", b_din_ready, 1'b1);
      if (k == 9) check("b2b_00_accepted", last_acc_b, 1'b1);
    end
    tick();
    check("b2b_back_idle", b_bit_valid, 1'b0);
    check("b2b_busy_idle", b_busy, 1'b0);
    check("b2b_queue_empty", qb.size(), 0);

    // Reset mid-word during 8'hC3, then a clean 8'h81.
    a_din = 8'hC3;
    a_din_valid = 1'b1;
    tick();
    a_din_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    #2 reset = 1'b0;
    #1;
    check("mid_rst_serial", a_serial_out, 1'b0);
    check("mid_rst_bit_valid", a_bit_valid, 1'b0);
    check("mid_rst_word_done", a_word_done, 1'b0);
    check("mid_rst_busy", a_busy, 1'b0);
    check("mid_rst_din_ready", a_din_ready, 1'b0);
    qa.delete();
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("post_rst_din_ready", a_din_ready, 1'b1);
    check("post_rst_busy", a_busy, 1'b0);
    a_din = 8'h81;
    a_din_valid = 1'b1;
    tick();
    check("w81_accepted", last_acc_a, 1'b1);
    a_din_valid = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("w81_downstream", ds_a, 8'h81);
    check("w81_queue_empty", qa.size(), 0);
    check("final_a_din_ready", a_din_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8: width of the parallel word and the number of serial bits per word.
REQ-002 Parameter GAP_CYCLES, default 1: idle cycles inserted after each word; the legal range is 0..15.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset (0 = reset asserted, 1 = run).
REQ-005 Port din, input, WIDTH: parallel word to serialize.
REQ-006 Port din_valid, input, 1: din holds a word offered for transfer.
REQ-007 Port din_ready, output, 1: the block can accept a word this cycle.
REQ-008 Port serial_out, output, 1: serial bit stream, registered, for the downstream data_in of the 8-bit shift register.
REQ-009 Port bit_valid, output, 1: serial_out carries a payload bit this cycle.
REQ-010 Port word_done, output, 1: one-cycle pulse coincident with the last bit of a word.
REQ-011 Port busy, output, 1: high in the SHIFT and GAP states.

Function
REQ-012 The block SHALL implement the states IDLE, SHIFT and GAP.
REQ-013 Accept SHALL occur on a rising edge where din_valid=1 and din_ready=1; only accepted words are captured.
REQ-014 din_ready SHALL be 1 in IDLE, 0 in GAP, and 0 in SHIFT, except in the last bit cycle of SHIFT when GAP_CYCLES=0.
REQ-015 On accept, the block SHALL load din into the internal shift register, clear the bit counter to 0 and enter SHIFT.
REQ-016 Latency SHALL be one cycle: the first bit (din[WIDTH-1], MSB first) appears on serial_out in the cycle after the accept edge.
REQ-017 In SHIFT, serial_out SHALL present bit WIDTH-1-k in bit cycle k (k = 0..WIDTH-1), with bit_valid=1.
REQ-018 word_done SHALL be 1 only in bit cycle WIDTH-1.
REQ-019 After bit cycle WIDTH-1, if GAP_CYCLES>0 the block SHALL enter GAP for exactly GAP_CYCLES cycles with serial_out=0 and bit_valid=0, then return to IDLE.
REQ-020 If GAP_CYCLES=0 and a word is accepted in bit cycle WIDTH-1, the block SHALL stay in SHIFT and emit the new word's MSB in the next cycle, with no bubble; without an accept it SHALL return to IDLE.
REQ-021 In IDLE, serial_out SHALL be 0 and bit_valid and word_done SHALL be 0.
REQ-022 Changes on din or din_valid while din_ready=0 SHALL have no effect on the word in flight.
REQ-023 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL not wrap within a word; it is reloaded to 0 on every accept.
REQ-024 The GAP counter SHALL count down from GAP_CYCLES-1 to 0; the exit to IDLE occurs on the edge where it reads 0.

Reset
REQ-025 While reset=0, the block SHALL immediately (asynchronously) force state=IDLE, shift register=0, bit counter=0, GAP counter=0, serial_out=0, bit_valid=0, word_done=0, busy=0 and din_ready=0.
REQ-026 On release of reset (reset=1), din_ready SHALL be 1 combinationally in IDLE, and the first accept is possible on the next rising edge.
REQ-027 If reset is asserted mid-word, the partial word SHALL be discarded and SHALL not resume after reset is released.

Verification
REQ-028 Basic word, WIDTH=8, GAP_CYCLES=1: accept din=8'hB2 -> next 8 cycles serial_out = 1,0,1,1,0,0,1,0; bit_valid=1 throughout; word_done=1 on the 8th cycle only; then 1 GAP cycle; din_ready returns to 1 on cycle 10.
REQ-029 Downstream check: drive serial_out into eightBitShiftRegister (data_in) with matching clk and reset, qualified by bit_valid -> after word_done, the shift register's data_out = 8'hB2.
REQ-030 Back-to-back, GAP_CYCLES=0: hold din_valid=1 with 8'hFF then 8'h00 -> 16 consecutive bit_valid cycles (8 ones, then 8 zeros); word_done pulses on cycles 8 and 16; no idle bubble.
REQ-031 Backpressure: change din from 8'hA5 to 8'h3C during SHIFT while din_valid=1 -> the serial stream is still 1,0,1,0,0,1,0,1; 8'h3C is accepted only when din_ready next goes to 1.
REQ-032 Reset mid-word: assert reset=0 after bit cycle 3 of 8'hC3 -> outputs are 0 immediately; after release, din_ready=1; a new word 8'h81 serializes as 1,0,0,0,0,0,0,1 with no residue from the earlier word.
REQ-033 Idle hold: din_valid=0 for 20 cycles after reset -> serial_out=0, bit_valid=0, busy=0 and din_ready=1 throughout.
